// File: rtl/dcache_lsu.sv
// rtl/dcache_lsu.sv - load/store unit bridging a pipeline request port to a data-cache command/response port
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned requests instead of issuing them.
module dcache_lsu #(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        req_wen,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        done_valid,
   output logic [63:0] done_rdata,
   output logic        done_err,
   output logic        done_misalign,
   output logic        dcache_cmd_valid,
   input  logic        dcache_cmd_ready,
   output logic [63:0] dcache_cmd_payload_addr,
   output logic        dcache_cmd_payload_wen,
   output logic [63:0] dcache_cmd_payload_wdata,
   output logic [7:0]  dcache_cmd_payload_wstrb,
   output logic [2:0]  dcache_cmd_payload_size,
   input  logic        dcache_rsp_valid,
   input  logic [63:0] dcache_rsp_payload_data
);

   localparam int CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [63:0]       addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_valid_q, done_valid_d;
   logic [63:0]       done_rdata_q, done_rdata_d;
   logic              done_err_q, done_err_d;
   logic              done_misalign_q, done_misalign_d;

   logic              trap_req;
   logic [5:0]        lane_shift;
   logic [7:0]        strb_base;
   logic [63:0]       load_shift;
   logic [63:0]       load_ext;
   logic              sx;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      trap_req = 1'b0;
      case (req_size)
         2'd0:    trap_req = 1'b0;
         2'd1:    trap_req = req_addr[0];
         2'd2:    trap_req = |req_addr[1:0];
         default: trap_req = |req_addr[2:0];
      endcase
   end
`else
   assign trap_req = 1'b0;
`endif

   assign lane_shift = {addr_q[2:0], 3'b000};

   always_comb begin
      strb_base = 8'h00;
      case (size_q)
         2'd0:    strb_base = 8'h01;
         2'd1:    strb_base = 8'h03;
         2'd2:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
   end

   // Lanes shifted past byte 7 fall off the top; misaligned stores lose them.
   assign dcache_cmd_valid         = (state_q == S_CMD);
   assign dcache_cmd_payload_addr  = {addr_q[63:3], 3'b000};
   assign dcache_cmd_payload_wen   = wen_q;
   assign dcache_cmd_payload_wdata = wdata_q << lane_shift;
   assign dcache_cmd_payload_wstrb = strb_base << addr_q[2:0];
   assign dcache_cmd_payload_size  = {1'b0, size_q};

   assign load_shift = dcache_rsp_payload_data >> lane_shift;
   assign sx         = ~uns_q;

   always_comb begin
      load_ext = load_shift;
      case (size_q)
         2'd0:    load_ext = {{56{sx & load_shift[7]}},  load_shift[7:0]};
         2'd1:    load_ext = {{48{sx & load_shift[15]}}, load_shift[15:0]};
         2'd2:    load_ext = {{32{sx & load_shift[31]}}, load_shift[31:0]};
         default: load_ext = load_shift;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      wen_d           = wen_q;
      wdata_d         = wdata_q;
      size_d          = size_q;
      uns_d           = uns_q;
      cnt_d           = cnt_q;
      done_valid_d    = 1'b0;
      done_rdata_d    = 64'd0;
      done_err_d      = 1'b0;
      done_misalign_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (trap_req) begin
                  done_valid_d    = 1'b1;
                  done_misalign_d = 1'b1;
               end else begin
                  addr_d  = req_addr;
                  wen_d   = req_wen;
                  wdata_d = req_wdata;
                  size_d  = req_size;
                  uns_d   = req_unsigned;
                  state_d = S_CMD;
               end
            end
         end
         S_CMD: begin
            if (dcache_cmd_ready) begin
               if (wen_q) begin
                  state_d      = S_IDLE;
                  done_valid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
         end
         S_WAIT: begin
            // A response arriving on the final allowed cycle beats the timeout.
            if (dcache_rsp_valid) begin
               state_d      = S_IDLE;
               done_valid_d = 1'b1;
               done_rdata_d = load_ext;
            end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
               state_d      = S_IDLE;
               done_valid_d = 1'b1;
               done_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         addr_q          <= 64'd0;
         wen_q           <= 1'b0;
         wdata_q         <= 64'd0;
         size_q          <= 2'd0;
         uns_q           <= 1'b0;
         cnt_q           <= '0;
         done_valid_q    <= 1'b0;
         done_rdata_q    <= 64'd0;
         done_err_q      <= 1'b0;
         done_misalign_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         wen_q           <= wen_d;
         wdata_q         <= wdata_d;
         size_q          <= size_d;
         uns_q           <= uns_d;
         cnt_q           <= cnt_d;
         done_valid_q    <= done_valid_d;
         done_rdata_q    <= done_rdata_d;
         done_err_q      <= done_err_d;
         done_misalign_q <= done_misalign_d;
      end
   end

   // Gated with reset so the request port closes the instant reset asserts.
   assign req_ready     = (state_q == S_IDLE) && !reset;
   assign done_valid    = done_valid_q;
   assign done_rdata    = done_rdata_q;
   assign done_err      = done_err_q;
   assign done_misalign = done_misalign_q;

endmodule

// File: tb/tb_dcache_lsu.sv
// tb/tb_dcache_lsu.sv - randomized self-checking bench for dcache_lsu against a behavioural model
// Honours LSU_MISALIGN_TRAP_EN when predicting misaligned-request behaviour.
module tb_dcache_lsu;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_wen;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        done_valid;
   logic [63:0] done_rdata;
   logic        done_err;
   logic        done_misalign;
   logic        dcache_cmd_valid;
   logic        dcache_cmd_ready;
   logic [63:0] dcache_cmd_payload_addr;
   logic        dcache_cmd_payload_wen;
   logic [63:0] dcache_cmd_payload_wdata;
   logic [7:0]  dcache_cmd_payload_wstrb;
   logic [2:0]  dcache_cmd_payload_size;
   logic        dcache_rsp_valid;
   logic [63:0] dcache_rsp_payload_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dcache_lsu #(.RSP_TIMEOUT(TMO)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .req_valid                (req_valid),
      .req_ready                (req_ready),
      .req_addr                 (req_addr),
      .req_wen                  (req_wen),
      .req_wdata                (req_wdata),
      .req_size                 (req_size),
      .req_unsigned             (req_unsigned),
      .done_valid               (done_valid),
      .done_rdata               (done_rdata),
      .done_err                 (done_err),
      .done_misalign            (done_misalign),
      .dcache_cmd_valid         (dcache_cmd_valid),
      .dcache_cmd_ready         (dcache_cmd_ready),
      .dcache_cmd_payload_addr  (dcache_cmd_payload_addr),
      .dcache_cmd_payload_wen   (dcache_cmd_payload_wen),
      .dcache_cmd_payload_wdata (dcache_cmd_payload_wdata),
      .dcache_cmd_payload_wstrb (dcache_cmd_payload_wstrb),
      .dcache_cmd_payload_size  (dcache_cmd_payload_size),
      .dcache_rsp_valid         (dcache_rsp_valid),
      .dcache_rsp_payload_data  (dcache_rsp_payload_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [63:0] addr,
                                            input logic [1:0] size, input logic uns);
      int nbits;
      logic [127:0] v;
      logic [127:0] mask;
      nbits = 8 << size;
      v     = {64'd0, data} >> ((addr % 8) * 8);
      mask  = (128'd1 << nbits) - 128'd1;
      v     = v & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
      return v[63:0];
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] wdata, input logic [63:0] addr);
      logic [127:0] v;
      v = {64'd0, wdata} << ((addr % 8) * 8);
      return v[63:0];
   endfunction

   function automatic logic [7:0] ref_wstrb(input logic [63:0] addr, input logic [1:0] size);
      logic [15:0] v;
      v = ((16'd1 << (1 << size)) - 16'd1) << (addr % 8);
      return v[7:0];
   endfunction

   function automatic bit ref_trap(input logic [63:0] addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_TRAP_EN
      return (addr % (64'd1 << size)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // rsp_at: WAIT cycle (1-based) carrying the response; anything above TMO means none.
   task automatic xact(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input int stall,
                       input int rsp_at, input logic [63:0] rdata);
      check("req_ready_idle", req_ready, 1);
      req_valid    = 1'b1;
      req_addr     = addr;
      req_wen      = wen;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      step();
      req_valid    = 1'b0;
      req_addr     = {$urandom, $urandom};
      req_wen      = 1'($urandom);
      req_wdata    = {$urandom, $urandom};
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      if (ref_trap(addr, size)) begin
         check("trap_done_valid", done_valid, 1);
         check("trap_misalign", done_misalign, 1);
         check("trap_err", done_err, 0);
         check("trap_no_cmd", dcache_cmd_valid, 0);
         return;
      end
      check("cmd_done_low", done_valid, 0);
      check("cmd_rdata_zero", done_rdata, 0);
      check("cmd_misalign_zero", done_misalign, 0);
      for (int i = 0; i <= stall; i++) begin
         check("cmd_valid", dcache_cmd_valid, 1);
         check("cmd_addr", dcache_cmd_payload_addr, {addr[63:3], 3'b000});
         check("cmd_wen", dcache_cmd_payload_wen, wen);
         check("cmd_size", dcache_cmd_payload_size, {1'b0, size});
         if (wen) begin
            check("cmd_wdata", dcache_cmd_payload_wdata, ref_wdata(wdata, addr));
            check("cmd_wstrb", dcache_cmd_payload_wstrb, ref_wstrb(addr, size));
         end
         dcache_cmd_ready        = (i == stall);
         dcache_rsp_valid        = 1'($urandom);
         dcache_rsp_payload_data = {$urandom, $urandom};
         step();
      end
      dcache_cmd_ready = 1'b0;
      dcache_rsp_valid = 1'b0;
      check("after_cmd_valid_low", dcache_cmd_valid, 0);
      if (wen) begin
         check("st_done_valid", done_valid, 1);
         check("st_done_err", done_err, 0);
         check("st_done_misalign", done_misalign, 0);
         return;
      end
      for (int w = 1; w <= TMO; w++) begin
         check("wait_done_low", done_valid, 0);
         check("wait_rdata_zero", done_rdata, 0);
         check("wait_err_zero", done_err, 0);
         if (w == rsp_at) begin
            dcache_rsp_valid        = 1'b1;
            dcache_rsp_payload_data = rdata;
         end
         step();
         dcache_rsp_valid = 1'b0;
         if (w == rsp_at) begin
            check("ld_done_valid", done_valid, 1);
            check("ld_rdata", done_rdata, ref_load(rdata, addr, size, uns));
            check("ld_err", done_err, 0);
            check("ld_misalign", done_misalign, 0);
            return;
         end
      end
      check("tmo_done_valid", done_valid, 1);
      check("tmo_err", done_err, 1);
      check("tmo_rdata", done_rdata, 0);
   endtask

   task automatic reset_mid(input bit in_wait);
      req_valid    = 1'b1;
      req_addr     = 64'h8000_0010;
      req_wen      = 1'b0;
      req_size     = 2'd3;
      req_unsigned = 1'b0;
      step();
      req_valid = 1'b0;
      if (in_wait) begin
         dcache_cmd_ready = 1'b1;
         step();
         dcache_cmd_ready = 1'b0;
      end
      reset = 1'b1;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_cmd_valid", dcache_cmd_valid, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_err", done_err, 0);
      check("rst_done_misalign", done_misalign, 0);
      step();
      reset = 1'b0;
      #1;
      check("rst_rel_req_ready", req_ready, 1);
      dcache_rsp_valid        = 1'b1;
      dcache_rsp_payload_data = 64'h1234_5678_9ABC_DEF0;
      step();
      dcache_rsp_valid = 1'b0;
      check("late_rsp_no_done", done_valid, 0);
      check("late_rsp_no_cmd", dcache_cmd_valid, 0);
      step();
      check("late_rsp_no_done2", done_valid, 0);
      check("late_rsp_req_ready", req_ready, 1);
   endtask

   initial begin
      reset                   = 1'b1;
      req_valid               = 1'b0;
      req_addr                = 64'd0;
      req_wen                 = 1'b0;
      req_wdata               = 64'd0;
      req_size                = 2'd0;
      req_unsigned            = 1'b0;
      dcache_cmd_ready        = 1'b0;
      dcache_rsp_valid        = 1'b0;
      dcache_rsp_payload_data = 64'd0;
      step();
      step();
      check("reset_req_ready", req_ready, 0);
      check("reset_done_valid", done_valid, 0);
      check("reset_cmd_valid", dcache_cmd_valid, 0);
      reset = 1'b0;
      #1;
      check("post_reset_req_ready", req_ready, 1);
      check("post_reset_done_err", done_err, 0);

      xact(64'h8000_0005, 1'b0, 64'd0, 2'd0, 1'b0, 0, 1, 64'h0000_8000_0000_0000);
      check("ld_byte_sext_const", done_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      xact(64'h8000_0002, 1'b1, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0, 0, 0, 64'd0);
      xact(64'h8000_0004, 1'b0, 64'd0, 2'd2, 1'b1, 4, 1, 64'hDEAD_BEEF_0000_0000);
      check("ld_word_stall_const", done_rdata, 64'h0000_0000_DEAD_BEEF);
      xact(64'h8000_0008, 1'b0, 64'd0, 2'd3, 1'b0, 0, TMO + 1, 64'd0);
      xact(64'h8000_0008, 1'b0, 64'd0, 2'd3, 1'b0, 0, TMO, 64'hFEDC_BA98_7654_3210);
      check("ld_rsp_at_tmo_const", done_rdata, 64'hFEDC_BA98_7654_3210);
      xact(64'h8000_0002, 1'b0, 64'd0, 2'd2, 1'b0, 0, 1, 64'h0123_4567_89AB_CDEF);
      xact(64'h8000_0007, 1'b1, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 1, 0, 64'd0);

      reset_mid(1'b1);
      reset_mid(1'b0);

      for (int n = 0; n < 300; n++) begin
         logic [63:0] a;
         a = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
         xact(a, 1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 1)),
              {$urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
